// File: rtl/ddr_s2mm_ctrl_if.sv
// Signal bundle between the fabric DDR write port and the DataMover S2MM channel.
// The controller uses the slave modport; a fabric-side driver uses the master modport.
interface ddr_s2mm_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int CMD_WIDTH  = 72,
  parameter int STS_WIDTH  = 32
);
  logic                    wreq_valid;
  logic                    wreq_ready;
  logic [ADDR_WIDTH-1:0]   wreq_addr;
  logic [SIZE_WIDTH-1:0]   wreq_size;

  logic                    wdata_valid;
  logic                    wdata_ready;
  logic                    wdata_last;
  logic [DATA_WIDTH-1:0]   wdata;

  logic                    wresp_valid;
  logic [1:0]              wresp;

  logic                    m_axis_s2mm_cmd_tvalid;
  logic                    m_axis_s2mm_cmd_tready;
  logic [CMD_WIDTH-1:0]    m_axis_s2mm_cmd_tdata;

  logic                    m_axis_s2mm_tvalid;
  logic                    m_axis_s2mm_tready;
  logic [DATA_WIDTH-1:0]   m_axis_s2mm_tdata;
  logic [DATA_WIDTH/8-1:0] m_axis_s2mm_tkeep;
  logic                    m_axis_s2mm_tlast;

  logic                    s_axis_s2mm_sts_tvalid;
  logic                    s_axis_s2mm_sts_tready;
  logic [STS_WIDTH-1:0]    s_axis_s2mm_sts_tdata;

  modport slave (
    input  wreq_valid, wreq_addr, wreq_size,
    output wreq_ready,
    input  wdata_valid, wdata_last, wdata,
    output wdata_ready,
    output wresp_valid, wresp,
    output m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tdata,
    input  m_axis_s2mm_cmd_tready,
    output m_axis_s2mm_tvalid, m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast,
    input  m_axis_s2mm_tready,
    input  s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tdata,
    output s_axis_s2mm_sts_tready
  );

  modport master (
    output wreq_valid, wreq_addr, wreq_size,
    input  wreq_ready,
    output wdata_valid, wdata_last, wdata,
    input  wdata_ready,
    input  wresp_valid, wresp,
    input  m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tdata,
    output m_axis_s2mm_cmd_tready,
    input  m_axis_s2mm_tvalid, m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast,
    output m_axis_s2mm_tready,
    output s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tdata,
    input  s_axis_s2mm_sts_tready
  );
endinterface

// File: rtl/ddr_s2mm_ctrl.sv
// Write-side responder: one wreq becomes one S2MM command + tagged burst, status maps to one wresp.
// Optional status-wait watchdog with stale-status absorption: define S2MM_TIMEOUT_EN.
module ddr_s2mm_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int CMD_WIDTH      = 72,
  parameter int ADDR_WIDTH     = 32,
  parameter int SIZE_WIDTH     = 16,
  parameter int STS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  ddr_s2mm_ctrl_if.slave        bus,
  output logic [2:0]            dbg_state
);
  // Every channel transfers on the rising edge where valid and ready are both high;
  // valid never waits for ready, and a source holds its payload stable until the transfer.

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_STS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [SIZE_WIDTH-1:0] beat_cnt;
  logic [3:0]            tag;
  logic [3:0]            cur_tag;
  logic                  last_err;
  logic [22:0]           btt;
  logic                  in_data;
  logic                  last_beat;
  logic                  wreq_hs, cmd_hs, beat_hs, sts_hs;
  logic [7:0]            sts_byte;
  logic                  tag_bad;
  logic [1:0]            sts_resp;
  logic                  to_expired;
  logic                  unused_sts;

  assign dbg_state = state;
  assign in_data   = (state == S_DATA);
  assign last_beat = (beat_cnt == (size_q - SIZE_WIDTH'(1)));
  assign btt       = 23'(bus.wreq_size) << BEAT_SHIFT;

  assign wreq_hs = bus.wreq_valid & bus.wreq_ready;
  assign cmd_hs  = bus.m_axis_s2mm_cmd_tvalid & bus.m_axis_s2mm_cmd_tready;
  assign beat_hs = bus.m_axis_s2mm_tvalid & bus.m_axis_s2mm_tready;
  assign sts_hs  = bus.s_axis_s2mm_sts_tvalid & bus.s_axis_s2mm_sts_tready;

  // Stream path is a combinational pass-through, gated so nothing leaks outside a burst.
  assign bus.wreq_ready         = (state == S_IDLE);
  assign bus.wdata_ready        = in_data & bus.m_axis_s2mm_tready;
  assign bus.m_axis_s2mm_tvalid = in_data & bus.wdata_valid;
  assign bus.m_axis_s2mm_tdata  = in_data ? bus.wdata : '0;
  assign bus.m_axis_s2mm_tkeep  = in_data ? '1 : '0;
  assign bus.m_axis_s2mm_tlast  = in_data & last_beat;

  assign sts_byte   = bus.s_axis_s2mm_sts_tdata[7:0];
  assign unused_sts = ^bus.s_axis_s2mm_sts_tdata[STS_WIDTH-1:8];
  assign tag_bad    = (sts_byte[3:0] != cur_tag);

  always_comb begin
    sts_resp = 2'b10;
    if (sts_byte[5])
      sts_resp = 2'b11;
    else if (sts_byte[6] | sts_byte[4] | tag_bad | last_err)
      sts_resp = 2'b10;
    else if (sts_byte[7])
      sts_resp = 2'b00;
  end

`ifdef S2MM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            tag_skip;

  assign to_expired = (state == S_STS) && !sts_hs &&
                      (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // A status that arrives after its request timed out carries a stale tag; swallow it in IDLE.
  assign bus.s_axis_s2mm_sts_tready = (state == S_STS) | ((state == S_IDLE) & tag_skip);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt   <= '0;
      tag_skip <= 1'b0;
    end else begin
      if (state != S_STS)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TO_W'(1);
      if (to_expired)
        tag_skip <= 1'b1;
      else if ((state == S_IDLE) && sts_hs)
        tag_skip <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign to_expired                 = 1'b0;
  assign bus.s_axis_s2mm_sts_tready = (state == S_STS);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (wreq_hs) state_nxt = (bus.wreq_size == '0) ? S_RESP : S_CMD;
      S_CMD:  if (cmd_hs) state_nxt = S_DATA;
      S_DATA: if (beat_hs && last_beat) state_nxt = S_STS;
      S_STS:  if (sts_hs || to_expired) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request bookkeeping and burst counting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      size_q   <= '0;
      beat_cnt <= '0;
      cur_tag  <= '0;
      last_err <= 1'b0;
      tag      <= '0;
    end else begin
      if ((state == S_IDLE) && wreq_hs) begin
        size_q   <= bus.wreq_size;
        beat_cnt <= '0;
        cur_tag  <= tag;
        last_err <= 1'b0;
      end
      if (cmd_hs)
        tag <= tag + 4'd1;
      if (beat_hs) begin
        beat_cnt <= beat_cnt + SIZE_WIDTH'(1);
        if (bus.wdata_last != last_beat)
          last_err <= 1'b1;
      end
    end
  end

  // Command: INCR, EOF, address, tag; built once at accept and held until taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.m_axis_s2mm_cmd_tvalid <= 1'b0;
      bus.m_axis_s2mm_cmd_tdata  <= '0;
    end else if ((state == S_IDLE) && (state_nxt == S_CMD)) begin
      bus.m_axis_s2mm_cmd_tvalid <= 1'b1;
      bus.m_axis_s2mm_cmd_tdata  <= {4'b0, tag, bus.wreq_addr, 1'b0, 1'b1, 6'b0, 1'b1, btt};
    end else if (cmd_hs) begin
      bus.m_axis_s2mm_cmd_tvalid <= 1'b0;
    end
  end

  // Response pulse lines up with the RESP state; zero-size and timeout both report SLVERR.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.wresp_valid <= 1'b0;
      bus.wresp       <= 2'b00;
    end else begin
      bus.wresp_valid <= (state_nxt == S_RESP);
      if ((state == S_STS) && sts_hs)
        bus.wresp <= sts_resp;
      else if (state_nxt == S_RESP)
        bus.wresp <= 2'b10;
    end
  end
endmodule

// File: tb/tb_ddr_s2mm_ctrl.sv
// Directed bench for ddr_s2mm_ctrl: basic write, backpressure, error mapping, last mismatch,
// zero size, reset abort, tag wrap and (with S2MM_TIMEOUT_EN) the status timeout.
module tb_ddr_s2mm_ctrl;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int SW  = 16;
  localparam int CW  = 72;
  localparam int STW = 32;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_s2mm_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                     .CMD_WIDTH(CW), .STS_WIDTH(STW)) bus();

  ddr_s2mm_ctrl #(.DATA_WIDTH(DW), .CMD_WIDTH(CW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                  .STS_WIDTH(STW), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int            checks = 0;
  int            errors = 0;
  logic [3:0]    exp_tag = 4'h0;
  logic [31:0]   txn_id = 32'h0;
  logic [CW-1:0] last_cmd;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wreq_valid             = 1'b0;
    bus.wreq_addr              = '0;
    bus.wreq_size              = '0;
    bus.wdata_valid            = 1'b0;
    bus.wdata_last             = 1'b0;
    bus.wdata                  = '0;
    bus.m_axis_s2mm_cmd_tready = 1'b0;
    bus.m_axis_s2mm_tready     = 1'b0;
    bus.s_axis_s2mm_sts_tvalid = 1'b0;
    bus.s_axis_s2mm_sts_tdata  = '0;
  endtask

  // One full request. Called at posedge+1; returns at posedge+1 after the wresp cycle.
  task automatic run_txn(input logic [AW-1:0] addr, input logic [SW-1:0] size,
                         input int cmd_delay, input bit toggle, input int last_pos,
                         input logic [7:0] sts_hi, input bit bad_tag, input bit withhold,
                         input logic [1:0] exp_resp, input int exp_lat);
    int            req_cyc = -1, cmd_cyc = -1, resp_cyc = -1;
    int            beat = 0, cmd_vis = 0, ncmd = 0, n = 0;
    bit            req_done = 0, cmd_done = 0, data_done, sts_done = 0, got_resp = 0, early = 0;
    logic [1:0]    resp_got = 2'b00;
    logic [CW-1:0] exp_cmd;
    exp_cmd   = {4'h0, exp_tag, addr, 8'h40, 1'b1, 23'(size) * 23'(DW / 8)};
    data_done = (size == 0);
    exp_q.delete();
    for (int i = 0; i < int'(size); i++) exp_q.push_back({txn_id, 32'(i)});
    while (!got_resp && n < 400) begin
      bus.wreq_valid             = !req_done;
      bus.wreq_addr              = addr;
      bus.wreq_size              = size;
      bus.m_axis_s2mm_cmd_tready = (cmd_vis >= cmd_delay);
      bus.m_axis_s2mm_tready     = toggle ? n[0] : 1'b1;
      bus.wdata_valid            = (beat < int'(size));
      bus.wdata                  = {txn_id, 32'(beat)};
      bus.wdata_last             = (beat == last_pos);
      bus.s_axis_s2mm_sts_tvalid = data_done && !sts_done && !withhold;
      bus.s_axis_s2mm_sts_tdata  = {24'h0, sts_hi[7:4], bad_tag ? (exp_tag ^ 4'h1) : exp_tag};
      @(negedge clk);
      if (bus.wreq_valid && bus.wreq_ready) begin
        req_done = 1;
        req_cyc  = cyc;
      end
      if (!cmd_done && bus.wdata_ready) early = 1;
      if (bus.m_axis_s2mm_cmd_tvalid) begin
        cmd_vis++;
        if (cmd_cyc < 0) cmd_cyc = cyc;
      end
      if (bus.m_axis_s2mm_cmd_tvalid && bus.m_axis_s2mm_cmd_tready) begin
        ncmd++;
        cmd_done = 1;
        last_cmd = bus.m_axis_s2mm_cmd_tdata;
        check("cmd_tdata", bus.m_axis_s2mm_cmd_tdata, exp_cmd);
      end
      if (bus.m_axis_s2mm_tvalid && bus.m_axis_s2mm_tready) begin
        if (exp_q.size() == 0)
          check("extra_beat", 1, 0);
        else
          check("tdata", bus.m_axis_s2mm_tdata, exp_q.pop_front());
        check("tlast", bus.m_axis_s2mm_tlast, beat == int'(size) - 1);
        beat++;
        if (beat == int'(size)) data_done = 1;
      end
      if (bus.s_axis_s2mm_sts_tvalid && bus.s_axis_s2mm_sts_tready) sts_done = 1;
      if (bus.wresp_valid) begin
        got_resp = 1;
        resp_got = bus.wresp;
        resp_cyc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    idle_inputs();
    check("resp_seen", got_resp, 1);
    check("wresp", resp_got, exp_resp);
    check("beat_count", beat, size);
    check("cmd_count", ncmd, (size != 0) ? 1 : 0);
    check("early_wdata_ready", early, 0);
    check("wresp_one_cycle", bus.wresp_valid, 0);
    check("back_to_idle", bus.wreq_ready, 1);
    if (size != 0) check("cmd_latency", cmd_cyc - req_cyc, 1);
    if (exp_lat >= 0) check("resp_latency", resp_cyc - req_cyc, exp_lat);
    if (size != 0) exp_tag = exp_tag + 4'h1;
    txn_id = txn_id + 32'h1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    #3;
    check("rst_wreq_ready", bus.wreq_ready, 1);
    check("rst_cmd_tvalid", bus.m_axis_s2mm_cmd_tvalid, 0);
    check("rst_cmd_tdata", bus.m_axis_s2mm_cmd_tdata, 0);
    check("rst_wresp_valid", bus.wresp_valid, 0);
    check("rst_wresp", bus.wresp, 0);
    check("rst_tvalid", bus.m_axis_s2mm_tvalid, 0);
    check("rst_wdata_ready", bus.wdata_ready, 0);
    check("rst_sts_tready", bus.s_axis_s2mm_sts_tready, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic write: size 4, everything ready, OKAY status; wresp at N+7.
    run_txn(32'h1000_0000, 16'd4, 0, 0, 3, 8'h80, 0, 0, 2'b00, 7);
    check("basic_cmd_literal", last_cmd, 72'h00_1000_0000_4080_0020);
    // Backpressure: cmd_tready after 5 cycles, tready toggling.
    run_txn(32'h2000_0040, 16'd8, 5, 1, 7, 8'h80, 0, 0, 2'b00, -1);
    // Error mapping.
    run_txn(32'h0000_1000, 16'd2, 0, 0, 1, 8'hA0, 0, 0, 2'b11, 5);
    run_txn(32'h0000_2000, 16'd2, 0, 0, 1, 8'hC0, 0, 0, 2'b10, -1);
    run_txn(32'h0000_3000, 16'd1, 0, 0, 0, 8'h90, 0, 0, 2'b10, -1);
    run_txn(32'h0000_4000, 16'd1, 0, 0, 0, 8'h00, 0, 0, 2'b10, -1);
    run_txn(32'h0000_5000, 16'd1, 0, 0, 0, 8'hE0, 0, 0, 2'b11, -1);
    run_txn(32'h0000_6000, 16'd3, 0, 0, 2, 8'h80, 1, 0, 2'b10, -1);
    // Last mismatch: wdata_last on beat 2 of 4.
    run_txn(32'h0000_7000, 16'd4, 0, 0, 1, 8'h80, 0, 0, 2'b10, -1);
    // Size 0: immediate SLVERR, no command, tag unchanged.
    run_txn(32'h0000_8000, 16'd0, 0, 0, -1, 8'h80, 0, 0, 2'b10, 1);
    run_txn(32'h0000_9000, 16'd1, 0, 0, 0, 8'h80, 0, 0, 2'b00, 4);

    // Reset while a burst is stalled in DATA.
    bus.wreq_valid             = 1'b1;
    bus.wreq_addr              = 32'h0000_A000;
    bus.wreq_size              = 16'd4;
    bus.m_axis_s2mm_cmd_tready = 1'b1;
    bus.wdata_valid            = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.wreq_valid = 1'b0;
    check("mid_tvalid_before", bus.m_axis_s2mm_tvalid, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_tvalid_drop", bus.m_axis_s2mm_tvalid, 0);
    check("mid_cmd_tvalid", bus.m_axis_s2mm_cmd_tvalid, 0);
    check("mid_wreq_ready", bus.wreq_ready, 1);
    check("mid_state", dbg_state, 0);
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("mid_no_wresp", bus.wresp_valid, 0);
    exp_tag = 4'h0;

    // Tag wrap: 17 single-beat requests after reset carry tags 0..15 then 0.
    for (int i = 0; i < 17; i++)
      run_txn(32'h0100_0000 + 32'(i * 8), 16'd1, 0, 0, 0, 8'h80, 0, 0, 2'b00, 4);
    check("tag_wrapped", last_cmd[67:64], 4'h0);

`ifdef S2MM_TIMEOUT_EN
    // Status withheld: SLVERR 16 cycles after entering STS (N+2+S+16).
    run_txn(32'h0000_B000, 16'd1, 0, 0, 0, 8'h80, 0, 1, 2'b10, 19);
    bus.s_axis_s2mm_sts_tvalid = 1'b1;
    bus.s_axis_s2mm_sts_tdata  = {24'h0, 4'h8, exp_tag - 4'h1};
    @(negedge clk);
    check("late_sts_tready", bus.s_axis_s2mm_sts_tready, 1);
    check("late_no_wresp", bus.wresp_valid, 0);
    @(posedge clk);
    #1;
    bus.s_axis_s2mm_sts_tvalid = 1'b0;
    check("skip_cleared", bus.s_axis_s2mm_sts_tready, 0);
    run_txn(32'h0000_C000, 16'd2, 0, 0, 1, 8'h80, 0, 0, 2'b00, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_s2mm_ctrl.md
# ddr_s2mm_ctrl

Write-side responder for the DDR test path. It accepts write requests and data beats on the `wreq`/`wdata`/`wresp` interface and converts each request into one AXI DataMover S2MM command plus a tagged AXI-Stream burst. It then translates the DataMover status word back into a single `wresp` pulse. It sits inside the block-design wrapper between the fabric-side DDR write port and the DataMover S2MM channel.

## Interface
Parameters:
- `DATA_WIDTH`, 64: write data / S2MM stream width in bits; must be a power of two, at least 8.
- `CMD_WIDTH`, 72: S2MM command width; equals `ADDR_WIDTH` + 40.
- `ADDR_WIDTH`, 32: byte address width.
- `SIZE_WIDTH`, 16: request size width, counted in beats.
- `STS_WIDTH`, 32: S2MM status width; only bits [7:0] are used.
- `TIMEOUT_CYCLES`, 4096: status-wait limit. Used only when `S2MM_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `wreq_valid` in 1; `wreq_ready` out 1; `wreq_addr` in ADDR_WIDTH (byte address); `wreq_size` in SIZE_WIDTH (beats).
- `wdata_valid` in 1; `wdata_ready` out 1; `wdata_last` in 1; `wdata` in DATA_WIDTH.
- `wresp_valid` out 1; `wresp` out 2 (00 OKAY, 10 SLVERR, 11 DECERR).
- `m_axis_s2mm_cmd_tvalid` out 1; `m_axis_s2mm_cmd_tready` in 1; `m_axis_s2mm_cmd_tdata` out CMD_WIDTH.
- `m_axis_s2mm_tvalid` out 1; `m_axis_s2mm_tready` in 1; `m_axis_s2mm_tdata` out DATA_WIDTH; `m_axis_s2mm_tkeep` out DATA_WIDTH/8; `m_axis_s2mm_tlast` out 1.
- `s_axis_s2mm_sts_tvalid` in 1; `s_axis_s2mm_sts_tready` out 1; `s_axis_s2mm_sts_tdata` in STS_WIDTH.

## Operation
State machine states: IDLE, CMD, DATA, STS, RESP.
- **IDLE**
  - `wreq_ready`=1.
  - On a `wreq` handshake: latch addr and size, clear `beat_cnt` and `last_err`.
  - size≠0 → CMD. size=0 → RESP with `wresp`=10; no command is issued.
- **CMD**
  - Command fields:
    - [22:0] BTT = size × DATA_WIDTH/8, zero-extended.
    - [23] = 1 (INCR).
    - [29:24] = 0.
    - [30] = 1 (EOF).
    - [31] = 0.
    - [63:32] = addr.
    - [67:64] = `tag`.
    - [71:68] = 0.
  - Command is held until `cmd_tready`. On the handshake, `tag` increments (4-bit, wraps 15→0) and the state moves to DATA.
- **DATA**
  - `m_axis_s2mm_tvalid` = `wdata_valid`; `wdata_ready` = `m_axis_s2mm_tready`. Both are combinational from the state register.
  - `tdata` = `wdata`; `tkeep` = all ones; `tlast` = (`beat_cnt` == size−1).
  - Each beat handshake increments `beat_cnt`.
  - `last_err` is set if `wdata_last` differs from the generated `tlast` on any accepted beat. The stream still carries exactly `size` beats.
  - Handshake of the final beat → STS.
- **STS**
  - `s_axis_s2mm_sts_tready`=1.
  - On the status handshake, with `sts[3:0]` ≠ expected tag treated as an internal error:
    - `wresp` = 11 if `sts[5]` (DECERR);
    - else 10 if `sts[6]`, `sts[4]`, tag mismatch, or `last_err`;
    - else 00 if `sts[7]`;
    - else 10.
  - → RESP.
- **RESP**
  - `wresp_valid`=1 for exactly one cycle, `wresp` valid alongside it; then → IDLE.
- **Outside DATA:** `wdata_ready`=0 and `m_axis_s2mm_tvalid`=0. Beats presented early are stalled, not dropped.
- **Outside STS:** `sts_tready`=0.

## Timing
- **Reset values:** state=IDLE, `tag`=0; `wreq_ready`=1 (combinational from state). All other outputs are 0, including `cmd_tdata`, `wresp`, and every valid/ready.
- **Reset mid-transaction:** immediate return to IDLE. `cmd_tvalid`, `tvalid` and `wresp_valid` drop asynchronously. No `wresp` is issued for the aborted request.
- **Registered outputs:** `cmd_tvalid`, `cmd_tdata`, `wresp_valid`, `wresp`.
- **Request accept → command:** request accepted at cycle N → `cmd_tvalid` high at N+1.
- **Fastest transaction:** with all readies tied high, the first beat transfers at N+2. Size S completes its data at N+1+S. Status accepted at N+2+S at the earliest; `wresp_valid` at N+3+S.
- **Concurrency:** one outstanding transaction. A new request is accepted no earlier than the cycle after the `wresp_valid` pulse.
- **Arithmetic:** `beat_cnt` is SIZE_WIDTH bits. The BTT product is at most 2^16 × 8 bytes, which fits in 23 bits for DATA_WIDTH up to 1024.
- **Size extremes:** size=1 yields a single beat with `tlast`=1. Size=65535 must not wrap `beat_cnt`.

## Configuration
- **`S2MM_TIMEOUT_EN` defined:** a counter runs while in STS.
  - If `TIMEOUT_CYCLES` elapse with no status handshake: go to RESP with `wresp`=10, and set sticky `tag_skip` so the next late status with the stale tag is consumed silently in IDLE (`sts_tready`=1 while `tag_skip`).
  - The counter clears on entering STS.
- **Undefined:** STS waits indefinitely; no counter or `tag_skip` logic is synthesized.

## Test plan
- **Basic write:** addr 0x1000_0000, size 4, all readies high, status 0x80|tag.
  - Command = 0x0_0_10000000_40800020 (BTT 32, tag 0).
  - 4 beats, `tlast` on beat 4; `wresp`=00 at N+7.
- **Backpressure:** size 8, `tready` toggling every cycle, `cmd_tready` delayed 5 cycles.
  - All 8 beats are delivered in order with none duplicated; `wdata_ready` stays low until the command is accepted.
- **Error mapping:** status bit 5 → `wresp`=11; status bit 6 → 10.
- **Last mismatch:** `wdata_last` asserted on beat 2 of 4.
  - Stream `tlast` only on beat 4; `wresp`=10 despite OKAY status.
- **Size 0 and tag wrap:** size 0 → `wresp`=10 with no `cmd_tvalid`; 17 consecutive requests → tag field 0…15, then 0.
- **Timeout (macro on):** `TIMEOUT_CYCLES`=16, status withheld → `wresp`=10 after 16 cycles.
  - A late status is absorbed. The next transaction completes with `wresp`=00.
